// File: rtl/lru_pkg.sv
// Shared types and helpers for the true-LRU age tracker: per-way record,
// update opcodes, clog2 and one-hot utilities.
package lru_pkg;

    localparam int MAX_WAYS = 16;

    typedef logic [3:0] age_t;

    typedef struct packed {
        logic valid;
        age_t age;
    } way_rec_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_HIT  = 2'd1,
        OP_MISS = 2'd2,
        OP_INV  = 2'd3
    } op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [MAX_WAYS-1:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    // Isolates the least significant set bit (two's-complement trick).
    function automatic logic [MAX_WAYS-1:0] lowest_set(input logic [MAX_WAYS-1:0] v);
        return v & (~v + 16'd1);
    endfunction

endpackage

// File: rtl/lru_age_update.sv
// Combinational next-state for one set: victim choice, promote-to-MRU on
// hit/miss and demote-to-LRU on invalidate, keeping ages a permutation.
module lru_age_update
    import lru_pkg::*;
#(
    parameter int WAYS = 8,
    parameter int CW   = 3
) (
    input  way_rec_t [WAYS-1:0] cur_i,
    input  op_e                 op_i,
    input  logic [WAYS-1:0]     way_i,
    output way_rec_t [WAYS-1:0] nxt_o,
    output logic [WAYS-1:0]     victim_o,
    output logic                victim_inv_o,
    output logic                err_o
);

    localparam age_t MRU_AGE = age_t'((1 << CW) - 1);

    logic [WAYS-1:0] invalid_s;
    logic [WAYS-1:0] lru_s;
    logic [WAYS-1:0] tgt_s;
    age_t            old_age_s;
    logic            promote_s;
    logic            demote_s;

    // Select the way being moved: the requested way when one-hot, else the miss victim.
    always_comb begin
        tgt_s        = '0;
        victim_o     = '0;
        victim_inv_o = 1'b0;
        err_o        = 1'b0;
        invalid_s    = '0;
        lru_s        = '0;
        for (int w = 0; w < WAYS; w++) begin
            invalid_s[w] = ~cur_i[w].valid;
            lru_s[w]     = (cur_i[w].age == 4'd0);
        end
        case (op_i)
            OP_HIT, OP_INV: begin
                if (is_onehot(MAX_WAYS'(way_i))) begin
                    tgt_s = way_i;
                end else begin
                    err_o = 1'b1;
                end
            end
            OP_MISS: begin
                if (|invalid_s) begin
                    tgt_s        = WAYS'(lowest_set(MAX_WAYS'(invalid_s)));
                    victim_inv_o = 1'b1;
                end else begin
                    tgt_s        = WAYS'(lowest_set(MAX_WAYS'(lru_s)));
                end
                victim_o = tgt_s;
            end
            default: begin
                tgt_s = '0;
            end
        endcase
    end

    // Move the target to MRU (shifting younger ways down) or to LRU (shifting older ways up).
    always_comb begin
        promote_s = ((op_i == OP_HIT) || (op_i == OP_MISS)) && (|tgt_s);
        demote_s  = (op_i == OP_INV) && (|tgt_s);
        old_age_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            old_age_s = old_age_s | (tgt_s[w] ? cur_i[w].age : 4'd0);
        end
        nxt_o = cur_i;
        for (int w = 0; w < WAYS; w++) begin
            if (promote_s && tgt_s[w]) begin
                nxt_o[w].age   = MRU_AGE;
                nxt_o[w].valid = cur_i[w].valid | (op_i == OP_MISS);
            end else if (promote_s && (cur_i[w].age > old_age_s)) begin
                nxt_o[w].age = cur_i[w].age - 4'd1;
            end else if (demote_s && tgt_s[w]) begin
                nxt_o[w].age   = 4'd0;
                nxt_o[w].valid = 1'b0;
            end else if (demote_s && (cur_i[w].age < old_age_s)) begin
                nxt_o[w].age = cur_i[w].age + 4'd1;
            end else begin
                nxt_o[w] = cur_i[w];
            end
        end
    end

endmodule

// File: rtl/lru_age_tracker.sv
// Per-set true-LRU age tracker with valid bits; requests win over invalidates,
// responses are registered one cycle after the request.
module lru_age_tracker
    import lru_pkg::*;
#(
    parameter int  WAYS = 8,
    parameter int  SETS = 128,
    localparam int AW   = clog2(SETS),
    localparam int CW   = clog2(WAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_valid,
    input  logic [AW-1:0]   i_req_set,
    input  logic            i_req_hit,
    input  logic [WAYS-1:0] i_req_way,
    input  logic            i_inv_valid,
    input  logic [AW-1:0]   i_inv_set,
    input  logic [WAYS-1:0] i_inv_way,
    output logic            o_inv_ready,
    output logic            o_rsp_valid,
    output logic [WAYS-1:0] o_victim_way,
    output logic            o_victim_was_invalid,
    output logic            o_err
);

    way_rec_t [WAYS-1:0] mem_q [SETS];

    op_e                 op_s;
    logic [AW-1:0]       set_s;
    logic [WAYS-1:0]     way_s;
    way_rec_t [WAYS-1:0] cur_s;
    way_rec_t [WAYS-1:0] nxt_s;
    logic [WAYS-1:0]     victim_s;
    logic                victim_inv_s;
    logic                err_s;

    logic                rsp_valid_d, rsp_valid_q;
    logic [WAYS-1:0]     victim_d, victim_q;
    logic                was_inv_d, was_inv_q;
    logic                err_d, err_q;

    // A request owns the single update path; an invalidate only runs in idle request cycles.
    always_comb begin
        op_s  = OP_NONE;
        set_s = i_req_set;
        way_s = i_req_way;
        if (i_req_valid) begin
            op_s = i_req_hit ? OP_HIT : OP_MISS;
        end else if (i_inv_valid) begin
            op_s  = OP_INV;
            set_s = i_inv_set;
            way_s = i_inv_way;
        end else begin
            op_s = OP_NONE;
        end
    end

    // State is read straight from the registers, so the next access sees this write.
    assign cur_s       = mem_q[set_s];
    assign o_inv_ready = ~i_req_valid;

    lru_age_update #(
        .WAYS (WAYS),
        .CW   (CW)
    ) u_update (
        .cur_i        (cur_s),
        .op_i         (op_s),
        .way_i        (way_s),
        .nxt_o        (nxt_s),
        .victim_o     (victim_s),
        .victim_inv_o (victim_inv_s),
        .err_o        (err_s)
    );

    // Response next-state; the update block already zeroes victim fields outside misses.
    always_comb begin
        rsp_valid_d = i_req_valid;
        victim_d    = victim_s;
        was_inv_d   = victim_inv_s;
        err_d       = err_s;
    end

    // Per-set age/valid storage, reset to age[w]=w with all ways empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem_q[s][w].valid <= 1'b0;
                    mem_q[s][w].age   <= age_t'(w);
                end
            end
        end else if (op_s != OP_NONE) begin
            mem_q[set_s] <= nxt_s;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            victim_q    <= '0;
            was_inv_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            victim_q    <= victim_d;
            was_inv_q   <= was_inv_d;
            err_q       <= err_d;
        end
    end

    assign o_rsp_valid          = rsp_valid_q;
    assign o_victim_way         = victim_q;
    assign o_victim_was_invalid = was_inv_q;
    assign o_err                = err_q;

endmodule

// File: tb/tb_lru_age_tracker.sv
// Bench for lru_age_tracker: recency-list model checked every cycle plus
// hand-computed victim/age expectations for the directed scenarios.
module tb_lru_age_tracker;

    localparam int WAYS = 8;
    localparam int SETS = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_req_valid, i_req_hit, i_inv_valid;
    logic [6:0] i_req_set, i_inv_set;
    logic [7:0] i_req_way, i_inv_way;
    logic       o_inv_ready, o_rsp_valid, o_victim_was_invalid, o_err;
    logic [7:0] o_victim_way;

    always #5 clk = ~clk;

    lru_age_tracker #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_req_valid          (i_req_valid),
        .i_req_set            (i_req_set),
        .i_req_hit            (i_req_hit),
        .i_req_way            (i_req_way),
        .i_inv_valid          (i_inv_valid),
        .i_inv_set            (i_inv_set),
        .i_inv_way            (i_inv_way),
        .o_inv_ready          (o_inv_ready),
        .o_rsp_valid          (o_rsp_valid),
        .o_victim_way         (o_victim_way),
        .o_victim_was_invalid (o_victim_was_invalid),
        .o_err                (o_err)
    );

    // Model: ord[s] lists ways from least to most recently used; a way's age is its position.
    int   ord [SETS][WAYS];
    bit   vld [SETS][WAYS];
    logic       exp_rsp = 1'b0, exp_vinv = 1'b0, exp_err = 1'b0;
    logic [7:0] exp_vic = 8'd0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pos_of(input int s, input int w);
        for (int p = 0; p < WAYS; p++) if (ord[s][p] == w) return p;
        return 0;
    endfunction

    function automatic void touch(input int s, input int w);
        int p;
        p = pos_of(s, w);
        for (int i = p; i < WAYS - 1; i++) ord[s][i] = ord[s][i+1];
        ord[s][WAYS-1] = w;
    endfunction

    function automatic void bury(input int s, input int w);
        int p;
        p = pos_of(s, w);
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endfunction

    function automatic int idx_of(input logic [7:0] v);
        int r;
        r = 0;
        for (int i = 0; i < WAYS; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                ord[s][w] = w;
                vld[s][w] = 1'b0;
            end
        exp_rsp = 1'b0; exp_vic = 8'd0; exp_vinv = 1'b0; exp_err = 1'b0;
    endfunction

    function automatic void model_step();
        int s, v;
        exp_rsp = i_req_valid; exp_vic = 8'd0; exp_vinv = 1'b0; exp_err = 1'b0;
        if (i_req_valid) begin
            s = int'(i_req_set);
            if (i_req_hit) begin
                if ($countones(i_req_way) == 1) touch(s, idx_of(i_req_way));
                else exp_err = 1'b1;
            end else begin
                v = -1;
                for (int w = WAYS - 1; w >= 0; w--) if (!vld[s][w]) v = w;
                if (v >= 0) exp_vinv = 1'b1;
                else v = ord[s][0];
                exp_vic = 8'(1 << v);
                vld[s][v] = 1'b1;
                touch(s, v);
            end
        end else if (i_inv_valid) begin
            s = int'(i_inv_set);
            if ($countones(i_inv_way) == 1) begin
                v = idx_of(i_inv_way);
                vld[s][v] = 1'b0;
                bury(s, v);
            end else begin
                exp_err = 1'b1;
            end
        end
    endfunction

    task automatic check_ages(input int s);
        for (int p = 0; p < WAYS; p++) begin
            check("age", 32'(dut.mem_q[s][ord[s][p]].age), 32'(p));
            check("valid", 32'(dut.mem_q[s][ord[s][p]].valid), 32'(vld[s][ord[s][p]]));
        end
    endtask

    task automatic drive(input logic rv, input logic [6:0] rs, input logic rh, input logic [7:0] rw,
                         input logic iv, input logic [6:0] is_, input logic [7:0] iw);
        i_req_valid = rv; i_req_set = rs; i_req_hit = rh; i_req_way = rw;
        i_inv_valid = iv; i_inv_set = is_; i_inv_way = iw;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
    endtask

    task automatic check_rsp(input string name, input logic r, input logic [7:0] vic,
                             input logic vi, input logic e);
        check(name, 32'({o_rsp_valid, o_victim_way, o_victim_was_invalid, o_err}),
              32'({r, vic, vi, e}));
    endtask

    initial begin
        rst = 1'b0;
        i_req_valid = 1'b0; i_req_set = 7'd0; i_req_hit = 1'b0; i_req_way = 8'd0;
        i_inv_valid = 1'b0; i_inv_set = 7'd0; i_inv_way = 8'd0;

        fork
            forever begin
                @(posedge clk or negedge rst);
                if (!rst) model_reset();
                else model_step();
            end
            forever begin
                @(negedge clk);
                check("cycle",
                      32'({o_rsp_valid, o_victim_way, o_victim_was_invalid, o_err, o_inv_ready}),
                      32'({exp_rsp, exp_vic, exp_vinv, exp_err, ~i_req_valid}));
            end
        join_none

        // Reset state
        #12;
        check_rsp("reset_out", 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_inv_ready", 32'(o_inv_ready), 32'd1);
        for (int w = 0; w < WAYS; w++) begin
            check("reset_age", 32'(dut.mem_q[5][w].age), 32'(w));
            check("reset_valid", 32'(dut.mem_q[5][w].valid), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Fill set 5: empty ways are taken lowest index first
        for (int i = 0; i < WAYS; i++) begin
            drive(1'b1, 7'd5, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
            check_rsp("fill5", 1'b1, 8'(1 << i), 1'b1, 1'b0);
        end
        idle();
        check_rsp("idle_zero", 1'b0, 8'h00, 1'b0, 1'b0);

        // Hit way 0 then miss evicts way 1
        drive(1'b1, 7'd5, 1'b1, 8'h01, 1'b0, 7'd0, 8'd0);
        check_rsp("hit0", 1'b1, 8'h00, 1'b0, 1'b0);
        idle();
        check("age0_mru", 32'(dut.mem_q[5][0].age), 32'd7);
        drive(1'b1, 7'd5, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
        check_rsp("miss_lru", 1'b1, 8'h02, 1'b0, 1'b0);
        idle();

        // Invalidate way 3, next miss refills it
        i_inv_valid = 1'b1; i_inv_set = 7'd5; i_inv_way = 8'h08;
        #1;
        check("inv_ready", 32'(o_inv_ready), 32'd1);
        @(posedge clk);
        #2;
        drive(1'b1, 7'd5, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
        check_rsp("miss_refill", 1'b1, 8'h08, 1'b1, 1'b0);
        idle();
        check_ages(5);

        // Set 9: fill, age ways 2 and 4 to the bottom, then back-to-back hits 2,4 and misses
        for (int i = 0; i < WAYS; i++) drive(1'b1, 7'd9, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b1, 8'h01, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b1, 8'h02, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b1, 8'h08, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b1, 8'h20, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b1, 8'h40, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b1, 8'h80, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b1, 8'h04, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b1, 8'h10, 1'b0, 7'd0, 8'd0);
        drive(1'b1, 7'd9, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
        check_rsp("bypass_miss1", 1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 7'd9, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
        check_rsp("bypass_miss2", 1'b1, 8'h02, 1'b0, 1'b0);
        idle();
        check_ages(9);

        // Non-one-hot hit: error, ages frozen
        drive(1'b1, 7'd9, 1'b1, 8'h03, 1'b0, 7'd0, 8'd0);
        check_rsp("hit_err", 1'b1, 8'h00, 1'b0, 1'b1);
        idle();
        check_rsp("err_pulse", 1'b0, 8'h00, 1'b0, 1'b0);
        check("err_age1", 32'(dut.mem_q[9][1].age), 32'd7);
        check("err_age3", 32'(dut.mem_q[9][3].age), 32'd0);
        check_ages(9);

        // Non-one-hot invalidate: error the cycle after acceptance
        drive(1'b0, 7'd0, 1'b0, 8'd0, 1'b1, 7'd9, 8'h0C);
        check_rsp("inv_err", 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        check_ages(9);

        // Request and invalidate together: invalidate stalls, then goes through
        i_req_valid = 1'b1; i_req_set = 7'd9; i_req_hit = 1'b1; i_req_way = 8'h80;
        i_inv_valid = 1'b1; i_inv_set = 7'd9; i_inv_way = 8'h40;
        #1;
        check("inv_blocked", 32'(o_inv_ready), 32'd0);
        @(posedge clk);
        #2;
        i_req_valid = 1'b0;
        #1;
        check("inv_unblocked", 32'(o_inv_ready), 32'd1);
        @(posedge clk);
        #2;
        idle();
        drive(1'b1, 7'd9, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
        check_rsp("miss_after_inv", 1'b1, 8'h40, 1'b1, 1'b0);
        idle();
        check_ages(9);

        // Reset with a response pending and another request in flight
        drive(1'b1, 7'd9, 1'b1, 8'h04, 1'b0, 7'd0, 8'd0);
        check_rsp("pre_reset", 1'b1, 8'h00, 1'b0, 1'b0);
        i_req_hit = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_rsp("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int w = 0; w < WAYS; w++) begin
            check("rst9_age", 32'(dut.mem_q[9][w].age), 32'(w));
            check("rst9_valid", 32'(dut.mem_q[9][w].valid), 32'd0);
        end
        i_req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive(1'b1, 7'd9, 1'b0, 8'd0, 1'b0, 7'd0, 8'd0);
        check_rsp("post_reset_miss", 1'b1, 8'h01, 1'b1, 1'b0);
        idle();
        check_ages(9);
        check_ages(5);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
